// File: rtl/seq_pkg.sv
// Shared definitions for the sequence engine: table depth, reset contents
// and the arbiter FSM state encoding.
package seq_pkg;

  localparam int SEQ_DEPTH = 8;
  localparam int SEQ_AW    = 3;

  // Reset table contents. Entry 0 sits in the low byte.
  localparam logic [SEQ_DEPTH-1:0][7:0] SEQ_INIT = {
    8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
  };

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/seq_table.sv
// Eight-entry sequence register file plus the shared sequence position.
// The read port always presents the entry at the current position, so a
// write committed on the same edge as a grant is visible in the first word.
module seq_table
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [SEQ_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pos_clr,
  input  logic              pos_inc,
  output logic [SEQ_AW-1:0] pos,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [SEQ_DEPTH];
  logic [SEQ_AW-1:0] pos_reg;

  // Table storage: reloads the initial sequence on reset, one write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SEQ_DEPTH; i++) begin
        mem_reg[i] <= DATA_W'(SEQ_INIT[i]);
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Position counter: clear wins over increment; increment wraps 7 -> 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_reg <= '0;
    end else if (pos_clr) begin
      pos_reg <= '0;
    end else if (pos_inc) begin
      pos_reg <= pos_reg + SEQ_AW'(1);
    end
  end

  assign pos     = pos_reg;
  assign rd_data = mem_reg[pos_reg];

endmodule

// File: rtl/seq_gen_arbiter.sv
// Round-robin arbiter sharing one sequence table between requesters.
// A granted requester receives a burst of words over valid/ready; the
// table is only writable while no burst is in progress.
module seq_gen_arbiter
  import seq_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  parameter  int LEN_W   = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ-1:0]       req_restart,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  output logic                     done,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_addr,
  input  logic [DATA_W-1:0]        cfg_data,
  output logic                     cfg_busy
);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [LEN_W:0]    remain_reg;   // one extra bit so a zero length means 2^LEN_W
  logic              done_reg;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   idx;
  logic [LEN_W-1:0]  pick_len;
  logic              busy;
  logic              take;
  logic              hs;
  logic              last_hs;
  logic [SEQ_AW-1:0] pos;
  logic [DATA_W-1:0] rd_data;

  // Round-robin pick: first pending request at or after rr_ptr, cyclically.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign pick_len = req_len[int'(pick_id)*LEN_W +: LEN_W];
  assign busy     = (state_reg == BURST);
  assign take     = (state_reg == IDLE) && pick_valid;
  assign hs       = busy && out_ready;
  assign last_hs  = hs && (remain_reg == (LEN_W+1)'(1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state and burst-facing outputs.
  always_comb begin
    state_next = state_reg;
    grant      = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_id     = '0;
    out_last   = 1'b0;
    cfg_busy   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) state_next = BURST;
      end
      BURST: begin
        grant[id_reg] = 1'b1;
        out_valid     = 1'b1;
        out_data      = rd_data;
        out_id        = id_reg;
        out_last      = (remain_reg == (LEN_W+1)'(1));
        cfg_busy      = 1'b1;
        if (last_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Winner, round-robin pointer, remaining-word count and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_reg     <= '0;
      rr_ptr_reg <= '0;
      remain_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= last_hs;
      if (take) begin
        id_reg     <= pick_id;
        rr_ptr_reg <= ID_W'((int'(pick_id) + 1) % NUM_REQ);
        remain_reg <= {(pick_len == '0), pick_len};
      end else if (hs) begin
        remain_reg <= remain_reg - (LEN_W+1)'(1);
      end
    end
  end

  assign done = done_reg;

  seq_table #(
    .DATA_W (DATA_W)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (cfg_we && !busy),
    .waddr   (cfg_addr),
    .wdata   (cfg_data),
    .pos_clr (take && req_restart[pick_id]),
    .pos_inc (hs),
    .pos     (pos),
    .rd_data (rd_data)
  );

endmodule
